// File: rtl/mio_arbiter.sv
// mio_arbiter: shares one fixed-latency memory/IO bus between the CPU and a
// secondary master (DMA/display fetch). CPU has priority; the secondary port
// is forced through after MAX_WAIT consecutive contested CPU grants.
//
// state | meaning
// IDLE  | no access in flight; a request here is granted and latched
// BUSY  | mem_en held for MEM_LAT cycles; read data captured on exit
// DONE  | one-cycle ready pulse to the owner; memory outputs low
`timescale 1ns/1ps

module mio_arbiter #(
    parameter int MEM_LAT  = 1,
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cpu_req,
    input  logic        cpu_we,
    input  logic [31:0] cpu_addr,
    input  logic [31:0] cpu_wdata,
    output logic        cpu_ready,
    output logic [31:0] cpu_rdata,
    input  logic        dma_req,
    input  logic        dma_we,
    input  logic [31:0] dma_addr,
    input  logic [31:0] dma_wdata,
    output logic        dma_ready,
    output logic [31:0] dma_rdata,
    output logic        mem_en,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        busy,
    output logic        owner
);

    localparam int CW = $clog2(MEM_LAT + 1);
    localparam int SW = $clog2(MAX_WAIT + 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(MEM_LAT - 1);
    localparam logic [SW-1:0] STREAK_MAX = SW'(MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [SW-1:0]  r_streak;
    logic           r_owner;
    logic           r_busy;
    logic           r_mem_en;
    logic           r_mem_we;
    logic [31:0]    r_mem_addr;
    logic [31:0]    r_mem_wdata;
    logic           r_cpu_ready;
    logic           r_dma_ready;
    logic [31:0]    r_cpu_rdata;
    logic [31:0]    r_dma_rdata;

    logic           w_any_req;
    logic           w_grant_dma;
    logic           w_cnt_last;

    // Arbitration decision for the IDLE cycle: CPU first unless the DMA port has waited MAX_WAIT times
    assign w_any_req   = cpu_req | dma_req;
    assign w_grant_dma = dma_req & (~cpu_req | (r_streak == STREAK_MAX));
    assign w_cnt_last  = (r_cnt == CNT_LAST);

    // Sequencer: grant and latch in IDLE, hold the bus in BUSY, pulse ready in DONE
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_streak    <= '0;
            r_owner     <= 1'b0;
            r_busy      <= 1'b0;
            r_mem_en    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_cpu_ready <= 1'b0;
            r_dma_ready <= 1'b0;
            r_cpu_rdata <= '0;
            r_dma_rdata <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_state     <= S_BUSY;
                        r_cnt       <= '0;
                        r_owner     <= w_grant_dma;
                        r_busy      <= 1'b1;
                        r_mem_en    <= 1'b1;
                        r_mem_we    <= w_grant_dma ? dma_we    : cpu_we;
                        r_mem_addr  <= w_grant_dma ? dma_addr  : cpu_addr;
                        r_mem_wdata <= w_grant_dma ? dma_wdata : cpu_wdata;
                        // streak counts only CPU wins that made the DMA port wait
                        if (w_grant_dma || !dma_req) begin
                            r_streak <= '0;
                        end else if (r_streak != STREAK_MAX) begin
                            r_streak <= r_streak + 1'b1;
                        end
                    end
                end
                S_BUSY: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_cnt_last) begin
                        if (!r_mem_we) begin
                            if (r_owner) begin
                                r_dma_rdata <= mem_rdata;
                            end else begin
                                r_cpu_rdata <= mem_rdata;
                            end
                        end
                        r_state     <= S_DONE;
                        r_mem_en    <= 1'b0;
                        r_mem_we    <= 1'b0;
                        r_mem_addr  <= '0;
                        r_mem_wdata <= '0;
                        r_cpu_ready <= ~r_owner;
                        r_dma_ready <= r_owner;
                    end
                end
                S_DONE: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_cpu_ready <= 1'b0;
                    r_dma_ready <= 1'b0;
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_busy      <= 1'b0;
                    r_mem_en    <= 1'b0;
                    r_mem_we    <= 1'b0;
                    r_mem_addr  <= '0;
                    r_mem_wdata <= '0;
                    r_cpu_ready <= 1'b0;
                    r_dma_ready <= 1'b0;
                end
            endcase
        end
    end

    assign cpu_ready = r_cpu_ready;
    assign dma_ready = r_dma_ready;
    assign cpu_rdata = r_cpu_rdata;
    assign dma_rdata = r_dma_rdata;
    assign mem_en    = r_mem_en;
    assign mem_we    = r_mem_we;
    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign busy      = r_busy;
    assign owner     = r_owner;

endmodule

// File: tb/tb_mio_arbiter.sv
// Bench for mio_arbiter: one instance with MEM_LAT=1 (arbitration table,
// starvation and streak sequences) and one with MEM_LAT=3 (multi-cycle
// access, input churn, back-to-back request, reset mid-access).
`timescale 1ns/1ps

module tb_mio_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst_n;

    // instance with MEM_LAT=1
    logic        c1_req, c1_we, d1_req, d1_we;
    logic [31:0] c1_addr, c1_wdata, d1_addr, d1_wdata, m1_rdata;
    logic        c1_rdy, d1_rdy, m1_en, m1_we, bsy1, own1;
    logic [31:0] c1_rd, d1_rd, m1_addr, m1_wdata;

    // instance with MEM_LAT=3
    logic        c3_req, c3_we, d3_req, d3_we;
    logic [31:0] c3_addr, c3_wdata, d3_addr, d3_wdata, m3_rdata;
    logic        c3_rdy, d3_rdy, m3_en, m3_we, bsy3, own3;
    logic [31:0] c3_rd, d3_rd, m3_addr, m3_wdata;

    mio_arbiter #(.MEM_LAT(1), .MAX_WAIT(4)) u_dut1 (
        .clk(clk), .reset(rst_n),
        .cpu_req(c1_req), .cpu_we(c1_we), .cpu_addr(c1_addr), .cpu_wdata(c1_wdata),
        .cpu_ready(c1_rdy), .cpu_rdata(c1_rd),
        .dma_req(d1_req), .dma_we(d1_we), .dma_addr(d1_addr), .dma_wdata(d1_wdata),
        .dma_ready(d1_rdy), .dma_rdata(d1_rd),
        .mem_en(m1_en), .mem_we(m1_we), .mem_addr(m1_addr), .mem_wdata(m1_wdata),
        .mem_rdata(m1_rdata), .busy(bsy1), .owner(own1)
    );

    mio_arbiter #(.MEM_LAT(3), .MAX_WAIT(4)) u_dut3 (
        .clk(clk), .reset(rst_n),
        .cpu_req(c3_req), .cpu_we(c3_we), .cpu_addr(c3_addr), .cpu_wdata(c3_wdata),
        .cpu_ready(c3_rdy), .cpu_rdata(c3_rd),
        .dma_req(d3_req), .dma_we(d3_we), .dma_addr(d3_addr), .dma_wdata(d3_wdata),
        .dma_ready(d3_rdy), .dma_rdata(d3_rd),
        .mem_en(m3_en), .mem_we(m3_we), .mem_addr(m3_addr), .mem_wdata(m3_wdata),
        .mem_rdata(m3_rdata), .busy(bsy3), .owner(own3)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    typedef struct {
        logic        cr, dr, cwe, dwe;
        logic [31:0] caddr, cwd, daddr, dwd, mrd;
        logic        e_own, e_we;
        logic [31:0] e_addr, e_wd, e_crd, e_drd;
    } vec_t;

    function automatic vec_t mkv(input logic cr, dr, cwe, dwe,
                                 input logic [31:0] caddr, cwd, daddr, dwd, mrd,
                                 input logic e_own, e_we,
                                 input logic [31:0] e_addr, e_wd, e_crd, e_drd);
        vec_t v;
        v.cr = cr; v.dr = dr; v.cwe = cwe; v.dwe = dwe;
        v.caddr = caddr; v.cwd = cwd; v.daddr = daddr; v.dwd = dwd; v.mrd = mrd;
        v.e_own = e_own; v.e_we = e_we; v.e_addr = e_addr; v.e_wd = e_wd;
        v.e_crd = e_crd; v.e_drd = e_drd;
        return v;
    endfunction

    // one full transaction on the MEM_LAT=1 instance, starting and ending in IDLE
    task automatic apply1(input vec_t v, input int idx);
        c1_req = v.cr; c1_we = v.cwe; c1_addr = v.caddr; c1_wdata = v.cwd;
        d1_req = v.dr; d1_we = v.dwe; d1_addr = v.daddr; d1_wdata = v.dwd;
        m1_rdata = v.mrd;
        @(posedge clk); #1;
        chk($sformatf("v%0d_busy_en", idx), {bsy1, m1_en}, 2'b11);
        chk($sformatf("v%0d_owner", idx), own1, v.e_own);
        chk($sformatf("v%0d_we", idx), m1_we, v.e_we);
        chk($sformatf("v%0d_addr", idx), m1_addr, v.e_addr);
        chk($sformatf("v%0d_wdata", idx), m1_wdata, v.e_wd);
        c1_req = 1'b0; d1_req = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("v%0d_ready", idx), {c1_rdy, d1_rdy}, {~v.e_own, v.e_own});
        chk($sformatf("v%0d_mem_done", idx), {m1_en, m1_we, m1_addr}, 34'h0);
        chk($sformatf("v%0d_cpu_rdata", idx), c1_rd, v.e_crd);
        chk($sformatf("v%0d_dma_rdata", idx), d1_rd, v.e_drd);
        @(posedge clk); #1;
        chk($sformatf("v%0d_idle", idx), {bsy1, c1_rdy, d1_rdy}, 3'b000);
    endtask

    // wait for the next BUSY cycle of the MEM_LAT=1 instance and report its owner
    task automatic wait_grant1(output logic own, output bit ok);
        ok  = 1'b0;
        own = 1'b0;
        for (int i = 0; i < 10 && !ok; i++) begin
            @(posedge clk); #1;
            if (m1_en) begin
                ok  = 1'b1;
                own = own1;
            end
        end
    endtask

    // one transaction on the MEM_LAT=3 instance; requests are dropped after the grant
    task automatic run3(input string tag, input logic e_own, input logic e_we,
                        input logic [31:0] e_addr, input logic [31:0] e_wd, input bit churn);
        int en_cnt, en_first, crdy, drdy, rdy_at;
        bit stable, mem_zero;
        en_cnt = 0; en_first = -1; crdy = 0; drdy = 0; rdy_at = -1;
        stable = 1'b1; mem_zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                c3_req = 1'b0; d3_req = 1'b0;
                if (churn) begin
                    c3_addr  = 32'hFFFF_FFF0;
                    c3_wdata = 32'hA5A5_A5A5;
                    c3_we    = 1'b1;
                    d3_addr  = 32'hEEEE_0000;
                end
            end
            if (m3_en) begin
                en_cnt++;
                if (en_first < 0) en_first = i;
                if (m3_we !== e_we || m3_addr !== e_addr || m3_wdata !== e_wd ||
                    own3 !== e_own || bsy3 !== 1'b1) stable = 1'b0;
            end
            if (c3_rdy || d3_rdy) begin
                if (c3_rdy) crdy++;
                if (d3_rdy) drdy++;
                rdy_at = i;
                if ({m3_en, m3_we, m3_addr, m3_wdata} !== 66'h0) mem_zero = 1'b0;
            end
        end
        chk({tag, "_en_cycles"}, en_cnt, 3);
        chk({tag, "_en_first"}, en_first, 0);
        chk({tag, "_stable"}, stable, 1'b1);
        chk({tag, "_ready_at"}, rdy_at, 3);
        chk({tag, "_ready_cnt"}, {crdy[7:0], drdy[7:0]}, e_own ? 16'h0001 : 16'h0100);
        chk({tag, "_mem_zero_done"}, mem_zero, 1'b1);
    endtask

    vec_t vt[9];
    logic starve_exp[10];
    logic clear_exp[9];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic o;
        bit   ok;
        int   rcnt;
        logic en5;
        bit   stray;

        vt[0] = mkv(1,0,0,0, 32'h40,  32'h0,       32'h44,  32'h0101_0101, 32'hDEAD_BEEF,
                    0,0, 32'h40,  32'h0,         32'hDEAD_BEEF, 32'h0);
        vt[1] = mkv(0,1,0,0, 32'h44,  32'h0101_0101, 32'h80, 32'h0,        32'h1111_2222,
                    1,0, 32'h80,  32'h0,         32'hDEAD_BEEF, 32'h1111_2222);
        vt[2] = mkv(1,0,1,0, 32'hC0,  32'hAAAA_5555, 32'h88, 32'h0,        32'hBAD0_BAD0,
                    0,1, 32'hC0,  32'hAAAA_5555, 32'hDEAD_BEEF, 32'h1111_2222);
        vt[3] = mkv(0,1,0,1, 32'hC4,  32'h0,       32'h104, 32'h0F0F_0F0F, 32'hBAD1_BAD1,
                    1,1, 32'h104, 32'h0F0F_0F0F, 32'hDEAD_BEEF, 32'h1111_2222);
        vt[4] = mkv(1,1,0,0, 32'h200, 32'h0,       32'h300, 32'h0,        32'h3333_4444,
                    0,0, 32'h200, 32'h0,         32'h3333_4444, 32'h1111_2222);
        vt[5] = mkv(1,1,1,0, 32'h204, 32'h1212_1212, 32'h304, 32'h0,      32'h5555_6666,
                    0,1, 32'h204, 32'h1212_1212, 32'h3333_4444, 32'h1111_2222);
        vt[6] = mkv(1,0,0,0, 32'h208, 32'h0,       32'h308, 32'h0,        32'h7777_8888,
                    0,0, 32'h208, 32'h0,         32'h7777_8888, 32'h1111_2222);
        vt[7] = mkv(1,1,0,0, 32'h20C, 32'h0,       32'h30C, 32'h0,        32'h9999_AAAA,
                    0,0, 32'h20C, 32'h0,         32'h9999_AAAA, 32'h1111_2222);
        vt[8] = mkv(0,1,1,0, 32'h210, 32'h0,       32'h400, 32'h0,        32'hBBBB_CCCC,
                    1,0, 32'h400, 32'h0,         32'h9999_AAAA, 32'hBBBB_CCCC);

        starve_exp = '{0,0,0,0,1,0,0,0,0,1};
        clear_exp  = '{0,0,0,0,0,0,0,0,1};

        rst_n = 1'b0;
        c1_req = 0; c1_we = 0; c1_addr = 0; c1_wdata = 0;
        d1_req = 0; d1_we = 0; d1_addr = 0; d1_wdata = 0; m1_rdata = 0;
        c3_req = 0; c3_we = 0; c3_addr = 0; c3_wdata = 0;
        d3_req = 0; d3_we = 0; d3_addr = 0; d3_wdata = 0; m3_rdata = 0;

        repeat (3) @(posedge clk);
        #1;
        chk("rst1_ctrl", {c1_rdy, d1_rdy, m1_en, m1_we, bsy1, own1}, 6'h0);
        chk("rst1_bus", {m1_addr, m1_wdata}, 64'h0);
        chk("rst1_rdata", {c1_rd, d1_rd}, 64'h0);
        chk("rst3_ctrl", {c3_rdy, d3_rdy, m3_en, m3_we, bsy3, own3}, 6'h0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        for (int k = 0; k < 9; k++) apply1(vt[k], k);

        // both held: four CPU grants then one forced DMA grant, repeating
        c1_req = 1; d1_req = 1; c1_we = 0; d1_we = 0;
        for (int k = 0; k < 10; k++) begin
            wait_grant1(o, ok);
            chk($sformatf("starve_grant%0d_seen", k), ok, 1'b1);
            chk($sformatf("starve_grant%0d_owner", k), o, starve_exp[k]);
        end
        c1_req = 0; d1_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // three contested CPU wins, an uncontested CPU win clears the streak
        c1_req = 1; d1_req = 1;
        for (int k = 0; k < 9; k++) begin
            wait_grant1(o, ok);
            chk($sformatf("clear_grant%0d_seen", k), ok, 1'b1);
            chk($sformatf("clear_grant%0d_owner", k), o, clear_exp[k]);
            if (k == 2) d1_req = 0;
            if (k == 3) d1_req = 1;
        end
        c1_req = 0; d1_req = 0;
        repeat (3) @(posedge clk);
        #1;

        // MEM_LAT=3: CPU read to load cpu_rdata
        c3_req = 1; c3_we = 0; c3_addr = 32'h800; c3_wdata = 32'h0; m3_rdata = 32'hCAFE_F00D;
        run3("c3_read", 1'b0, 1'b0, 32'h800, 32'h0, 1'b0);
        chk("c3_read_cpu_rdata", c3_rd, 32'hCAFE_F00D);
        chk("c3_read_dma_rdata", d3_rd, 32'h0);

        // DMA write: three stable write cycles, rdata untouched
        d3_req = 1; d3_we = 1; d3_addr = 32'h100; d3_wdata = 32'h1234_5678; m3_rdata = 32'h0BAD_F00D;
        run3("d3_write", 1'b1, 1'b1, 32'h100, 32'h1234_5678, 1'b0);
        chk("d3_write_cpu_rdata", c3_rd, 32'hCAFE_F00D);
        chk("d3_write_dma_rdata", d3_rd, 32'h0);

        // input churn during BUSY leaves the latched access alone
        c3_req = 1; c3_we = 0; c3_addr = 32'h900; c3_wdata = 32'h0; m3_rdata = 32'h600D_CAFE;
        run3("churn", 1'b0, 1'b0, 32'h900, 32'h0, 1'b1);
        chk("churn_cpu_rdata", c3_rd, 32'h600D_CAFE);
        c3_we = 0; c3_wdata = 0;

        // request held through DONE starts a second access
        c3_req = 1; c3_addr = 32'hA00; m3_rdata = 32'h1122_3344;
        rcnt = 0; en5 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (c3_rdy) rcnt++;
            if (i == 5) begin
                en5 = m3_en;
                c3_req = 0;
            end
        end
        chk("hold_second_en", en5, 1'b1);
        chk("hold_ready_cnt", rcnt, 2);
        chk("hold_cpu_rdata", c3_rd, 32'h1122_3344);

        // reset asserted mid-BUSY
        c3_req = 1; c3_addr = 32'hB00; m3_rdata = 32'h55AA_55AA;
        @(posedge clk); #1;
        c3_req = 0;
        chk("rstmid_pre_en", m3_en, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk("rstmid_ctrl", {c3_rdy, d3_rdy, m3_en, m3_we, bsy3, own3}, 6'h0);
        chk("rstmid_bus", {m3_addr, m3_wdata}, 64'h0);
        chk("rstmid_rdata", {c3_rd, d3_rd}, 64'h0);
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
        stray = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            if (c3_rdy || d3_rdy || bsy3 || m3_en) stray = 1'b1;
        end
        chk("rstmid_no_stray", stray, 1'b0);

        c3_req = 1; c3_we = 0; c3_addr = 32'hC00; m3_rdata = 32'h0F1E_2D3C;
        run3("post_rst", 1'b0, 1'b0, 32'hC00, 32'h0, 1'b0);
        chk("post_rst_cpu_rdata", c3_rd, 32'h0F1E_2D3C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
